// File: rtl/ws2812b_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws2812b_chain_ctrl                                              |
// | Purpose  : Frame sequencer for a daisy-chained WS2812B strip. On a frame   |
// |            request it reads NUM_LEDS 24-bit pixels from an external pixel  |
// |            RAM, scales them by a global brightness and hands them one at a |
// |            time to a single-pixel WS2812B driver (en/busy handshake).      |
// |            After the last pixel it holds the line idle for the latch gap   |
// |            and then pulses frame_done.                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_i          system clock                                              |
// |   rst_i          synchronous reset, active low                             |
// |   start_i        frame request, single-cycle pulse                         |
// |   brightness_i   global scale, sampled when a frame is accepted            |
// |   pix_rd_o       pixel RAM read strobe                                     |
// |   pix_addr_o     pixel index presented with pix_rd_o                       |
// |   pix_data_i     {R,G,B}, valid one cycle after pix_rd_o                   |
// |   drv_en_o       one-cycle load pulse to the driver                        |
// |   drv_red_o      scaled red to driver                                      |
// |   drv_green_o    scaled green to driver                                    |
// |   drv_blue_o     scaled blue to driver                                     |
// |   drv_busy_i     driver is shifting a pixel out                            |
// |   frame_busy_o   high from frame accept until frame_done                   |
// |   frame_done_o   one-cycle pulse after the latch gap                       |
// |   err_to_o       sticky: driver never went busy; cleared on next accept    |
// +----------------------------------------------------------------------------+
module ws2812b_chain_ctrl #(
  parameter  int unsigned NUM_LEDS = 8,
  parameter  int unsigned CLK_FREQ = 27_000_000,
  parameter  int unsigned LATCH_US = 300,
  parameter  int unsigned BUSY_TO  = 4096,
  localparam int unsigned AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [7:0]    brightness_i,
  output logic          pix_rd_o,
  output logic [AW-1:0] pix_addr_o,
  input  logic [23:0]   pix_data_i,
  output logic          drv_en_o,
  output logic [7:0]    drv_red_o,
  output logic [7:0]    drv_green_o,
  output logic [7:0]    drv_blue_o,
  input  logic          drv_busy_i,
  output logic          frame_busy_o,
  output logic          frame_done_o,
  output logic          err_to_o
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int unsigned LATCH_CYC  = CLK_FREQ / 1_000_000 * LATCH_US;
  // Both waits last at least one cycle so degenerate settings stay sane.
  localparam int unsigned LATCH_LAST = (LATCH_CYC > 0) ? LATCH_CYC - 1 : 0;
  localparam int unsigned BUSY_LAST  = (BUSY_TO > 0) ? BUSY_TO - 1 : 0;
  localparam int unsigned CNT_MAX    = (LATCH_LAST > BUSY_LAST) ? LATCH_LAST : BUSY_LAST;
  localparam int unsigned CW         = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CW-1:0] LATCH_END = CW'(LATCH_LAST);
  localparam logic [CW-1:0] BUSY_END  = CW'(BUSY_LAST);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_LEDS - 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_LOAD      = 3'd3,
    S_WAIT_HI   = 3'd4,
    S_WAIT_LO   = 3'd5,
    S_LATCH     = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q,   idx_d;
  logic [7:0]      bri_q,   bri_d;
  logic            pend_q,  pend_d;
  logic            err_q,   err_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [7:0]      red_q,   red_d;
  logic [7:0]      grn_q,   grn_d;
  logic [7:0]      blu_q,   blu_d;

  // c * (bri + 1) fits in 16 bits (255 * 256 = 65280); the upper byte is the
  // scaled value, so bri = 255 is an identity and bri = 0 always yields 0.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bri_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bri_q   <= bri_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bri_d   = bri_q;
    pend_d  = pend_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    red_d   = red_q;
    grn_d   = grn_q;
    blu_d   = blu_q;

    // Any request arriving while a frame is in flight (DONE included) is
    // remembered once; further requests coalesce into the same flag.
    if (start_i && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // A pending request is served here, one cycle after DONE, so the
        // brightness seen on this cycle is the one that applies.
        if (start_i || pend_q) begin
          bri_d   = brightness_i;
          idx_d   = '0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_WAIT_DATA;
      end

      S_WAIT_DATA: begin
        red_d   = scale(pix_data_i[23:16], bri_q);
        grn_d   = scale(pix_data_i[15:8],  bri_q);
        blu_d   = scale(pix_data_i[7:0],   bri_q);
        state_d = S_LOAD;
      end

      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT_HI;
      end

      S_WAIT_HI: begin
        if (drv_busy_i) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == BUSY_END) begin
          // Driver never acknowledged: abandon the rest of the frame but
          // still close it out cleanly with a latch gap.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAIT_LO: begin
        if (!drv_busy_i) begin
          if (idx_q == IDX_LAST) begin
            cnt_d   = '0;
            state_d = S_LATCH;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end

      S_LATCH: begin
        if (cnt_q == LATCH_END) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pix_rd_o     = (state_q == S_FETCH);
  assign pix_addr_o   = pix_rd_o ? idx_q : '0;
  assign drv_en_o     = (state_q == S_LOAD);
  assign drv_red_o    = red_q;
  assign drv_green_o  = grn_q;
  assign drv_blue_o   = blu_q;
  assign frame_busy_o = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_DONE);
  assign err_to_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ws2812b_chain_ctrl                                           |
// | Purpose  : Self-checking bench for ws2812b_chain_ctrl. Instance A drives a  |
// |            4-pixel chain, instance B a single pixel with a fixed 30-cycle  |
// |            driver busy time. Expected pixels come from a plain-arithmetic  |
// |            brightness model applied to the bench's own RAM contents.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ws2812b_chain_ctrl;

  localparam int L       = 20;   // latch cycles: 1 MHz * 20 us
  localparam int BUSY_TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A (4 pixels) ----------------
  logic        start_a = 1'b0;
  logic [7:0]  bri_a = 8'd0;
  logic        pix_rd_a, drv_en_a, busy_a, fbusy_a, fdone_a, err_a;
  logic [1:0]  pix_addr_a;
  logic [23:0] pix_data_a;
  logic [7:0]  r_a, g_a, b_a;
  logic [23:0] ram_a [4];
  int          busy_len_a = 8;
  logic        tie_low_a = 1'b0;
  int          bcnt_a;

  ws2812b_chain_ctrl #(
    .NUM_LEDS(4), .CLK_FREQ(1_000_000), .LATCH_US(L), .BUSY_TO(BUSY_TO)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .brightness_i(bri_a),
    .pix_rd_o(pix_rd_a), .pix_addr_o(pix_addr_a), .pix_data_i(pix_data_a),
    .drv_en_o(drv_en_a), .drv_red_o(r_a), .drv_green_o(g_a), .drv_blue_o(b_a),
    .drv_busy_i(busy_a), .frame_busy_o(fbusy_a), .frame_done_o(fdone_a),
    .err_to_o(err_a)
  );

  always @(posedge clk) if (pix_rd_a) pix_data_a <= ram_a[pix_addr_a];

  // Driver model: busy for busy_len_a cycles after each load pulse.
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_a <= 1'b0;
      bcnt_a <= 0;
    end else if (drv_en_a && !tie_low_a) begin
      busy_a <= 1'b1;
      bcnt_a <= busy_len_a - 1;
    end else if (busy_a) begin
      if (bcnt_a == 0) busy_a <= 1'b0;
      else             bcnt_a <= bcnt_a - 1;
    end
  end

  // ---------------- instance B (1 pixel) ----------------
  logic        start_b = 1'b0;
  logic        pix_rd_b, drv_en_b, busy_b, fbusy_b, fdone_b, err_b;
  logic [0:0]  pix_addr_b;
  logic [23:0] pix_data_b;
  logic [7:0]  r_b, g_b, b_b;
  int          bcnt_b;

  ws2812b_chain_ctrl #(
    .NUM_LEDS(1), .CLK_FREQ(1_000_000), .LATCH_US(L), .BUSY_TO(BUSY_TO)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .brightness_i(8'd255),
    .pix_rd_o(pix_rd_b), .pix_addr_o(pix_addr_b), .pix_data_i(pix_data_b),
    .drv_en_o(drv_en_b), .drv_red_o(r_b), .drv_green_o(g_b), .drv_blue_o(b_b),
    .drv_busy_i(busy_b), .frame_busy_o(fbusy_b), .frame_done_o(fdone_b),
    .err_to_o(err_b)
  );

  always @(posedge clk) if (pix_rd_b) pix_data_b <= 24'h123456 ^ {23'd0, pix_addr_b};

  always @(posedge clk) begin
    if (!rst_n) begin
      busy_b <= 1'b0;
      bcnt_b <= 0;
    end else if (drv_en_b) begin
      busy_b <= 1'b1;
      bcnt_b <= 29;
    end else if (busy_b) begin
      if (bcnt_b == 0) busy_b <= 1'b0;
      else             bcnt_b <= bcnt_b - 1;
    end
  end

  // ---------------- monitors (append-only records) ----------------
  logic [23:0] got_a [$];
  int          addr_a [$];
  int          gap_a [$];
  int          done_a = 0;
  int          fall_cyc_a = 0;
  logic        busy_prev_a = 1'b0;
  int          en_b = 0;
  int          done_b = 0;
  int          done_cyc_b = 0;

  always @(negedge clk) begin
    if (drv_en_a) got_a.push_back({r_a, g_a, b_a});
    if (pix_rd_a) addr_a.push_back(int'(pix_addr_a));
    if (busy_prev_a && !busy_a) fall_cyc_a = cyc;
    busy_prev_a = busy_a;
    if (fdone_a) begin
      done_a = done_a + 1;
      gap_a.push_back(cyc - fall_cyc_a);
    end
    if (drv_en_b) en_b = en_b + 1;
    if (fdone_b) begin
      done_b = done_b + 1;
      done_cyc_b = cyc;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference brightness model: each channel is (c * (b + 1)) / 256.
  function automatic logic [23:0] ref_px(input logic [23:0] p, input int b);
    int r, g, bl;
    r  = (int'(p[23:16]) * (b + 1)) / 256;
    g  = (int'(p[15:8])  * (b + 1)) / 256;
    bl = (int'(p[7:0])   * (b + 1)) / 256;
    return {r[7:0], g[7:0], bl[7:0]};
  endfunction

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (done_a < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(done_a >= target), 32'd1);
  endtask

  task automatic check_frame_a(input string tag, input int n0, input int bri);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_px"}, 32'(got_a[n0 + i]), 32'(ref_px(ram_a[i], bri)));
    end
  endtask

  // Full frame on A: returns the index of its first recorded pixel.
  task automatic run_frame_a(input string tag, output int n0);
    int d0, a0;
    n0 = got_a.size();
    a0 = addr_a.size();
    d0 = done_a;
    pulse_a();
    chk({tag, "_fbusy"}, 32'(fbusy_a), 32'd1);
    wait_done_a({tag, "_done"}, d0 + 1, 2000);
    @(posedge clk); #1;
    chk({tag, "_fbusy_end"}, 32'(fbusy_a), 32'd0);
    chk({tag, "_npix"}, 32'(got_a.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) chk({tag, "_addr"}, 32'(addr_a[a0 + i]), 32'(i));
    chk({tag, "_gap"}, 32'(gap_a[gap_a.size() - 1] >= L && gap_a[gap_a.size() - 1] <= L + 2), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0, d0, k, acc, diff;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({pix_rd_a, pix_addr_a, drv_en_a, fbusy_a, fdone_a, err_a}), 32'd0);
    chk("rst_colors", 32'({r_a, g_a, b_a}), 32'd0);
    chk("rst_outputs_b", 32'({pix_rd_b, drv_en_b, fbusy_b, fdone_b, err_b}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Primary colours at full brightness pass through unchanged, in order.
    ram_a[0] = 24'hFF0000; ram_a[1] = 24'h00FF00; ram_a[2] = 24'h0000FF; ram_a[3] = 24'hFFFFFF;
    bri_a = 8'd255;
    run_frame_a("t1", n0);
    chk("t1_p0", 32'(got_a[n0 + 0]), 32'h00FF0000);
    chk("t1_p1", 32'(got_a[n0 + 1]), 32'h0000FF00);
    chk("t1_p2", 32'(got_a[n0 + 2]), 32'h000000FF);
    chk("t1_p3", 32'(got_a[n0 + 3]), 32'h00FFFFFF);
    chk("t1_ndone", 32'(done_a), 32'd1);

    // Half and zero brightness.
    ram_a[0] = 24'h80FF01;
    bri_a = 8'd127;
    run_frame_a("t2a", n0);
    chk("t2_half", 32'(got_a[n0]), 32'h00407F00);
    check_frame_a("t2a", n0, 127);
    bri_a = 8'd0;
    run_frame_a("t2b", n0);
    for (int i = 0; i < 4; i++) chk("t2_zero", 32'(got_a[n0 + i]), 32'd0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) ram_a[i] = 24'($urandom);
      bri_a = 8'($urandom_range(0, 255));
      busy_len_a = int'($urandom_range(2, 20));
      run_frame_a("rnd", n0);
      check_frame_a("rnd", n0, int'(bri_a));
    end

    // Driver never answers: timeout, truncated frame, sticky error.
    tie_low_a = 1'b1;
    n0 = got_a.size();
    d0 = done_a;
    pulse_a();
    wait_done_a("t3_done", d0 + 1, 500);
    repeat (50) @(posedge clk);
    #1;
    chk("t3_err", 32'(err_a), 32'd1);
    chk("t3_one_en", 32'(got_a.size() - n0), 32'd1);
    chk("t3_ndone", 32'(done_a - d0), 32'd1);
    tie_low_a = 1'b0;
    bri_a = 8'd255;
    run_frame_a("t3b", n0);
    chk("t3_err_clr", 32'(err_a), 32'd0);
    check_frame_a("t3b", n0, 255);

    // Three mid-frame requests coalesce into exactly one follow-on frame,
    // which samples the brightness present when it is accepted.
    n0 = got_a.size();
    d0 = done_a;
    bri_a = 8'd200;
    pulse_a();
    k = 0;
    while (got_a.size() < n0 + 1 && k < 200) begin @(negedge clk); #1; k++; end
    pulse_a(); repeat (3) @(posedge clk);
    pulse_a(); repeat (3) @(posedge clk);
    pulse_a();
    bri_a = 8'd50;
    wait_done_a("t4_done", d0 + 2, 3000);
    repeat (200) @(posedge clk);
    #1;
    chk("t4_ndone", 32'(done_a - d0), 32'd2);
    chk("t4_nen", 32'(got_a.size() - n0), 32'd8);
    check_frame_a("t4f1", n0, 200);
    check_frame_a("t4f2", n0 + 4, 50);

    // Reset while the third pixel (index 2) is being shifted out.
    n0 = got_a.size();
    d0 = done_a;
    busy_len_a = 10;
    pulse_a();
    k = 0;
    while (!(got_a.size() >= n0 + 3 && busy_a) && k < 500) begin @(negedge clk); #1; k++; end
    chk("t5_reached", 32'(got_a.size() >= n0 + 3 && busy_a), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_out", 32'({pix_rd_a, pix_addr_a, drv_en_a, fbusy_a, fdone_a, err_a}), 32'd0);
    chk("t5_rst_col", 32'({r_a, g_a, b_a}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t5_no_done", 32'(done_a - d0), 32'd0);
    chk("t5_no_more_en", 32'(got_a.size() - n0), 32'd3);
    run_frame_a("t5b", n0);
    check_frame_a("t5b", n0, 50);

    // Single-pixel chain, 30-cycle busy: done at accept + 4 + 30 + L + 1 (+-1).
    d0 = done_b;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    acc = cyc;
    k = 0;
    while (done_b == d0 && k < 500) begin @(negedge clk); #1; k++; end
    chk("t6_done", 32'(done_b - d0), 32'd1);
    diff = done_cyc_b - acc;
    chk("t6_latency", 32'(diff >= 34 + L && diff <= 36 + L), 32'd1);
    chk("t6_nen", 32'(en_b), 32'd1);
    chk("t6_err", 32'(err_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
